// File: rtl/serial_alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_seq_if
// Description : Bundle between the issue logic, the bit-serial sequencer and
//               the external 1-bit ALU slice.
//               Issue side : start, a, b, ctl  ->  busy, done, result, zero, cout
//               Slice side : slice_a/b/cin/inv/ctl  ->  slice_out, slice_cout
//               slave  : the sequencer (serial_alu_seq)
//               master : the issue logic together with the slice
// Revision    : 1.0  initial release
// ============================================================================
interface serial_alu_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       ctl;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             cout;
   logic             slice_a;
   logic             slice_b;
   logic             slice_cin;
   logic             slice_inv;
   logic [2:0]       slice_ctl;
   logic             slice_out;
   logic             slice_cout;

   modport slave (
      input  start, a, b, ctl, slice_out, slice_cout,
      output busy, done, result, zero, cout,
             slice_a, slice_b, slice_cin, slice_inv, slice_ctl
   );

   modport master (
      output start, a, b, ctl, slice_out, slice_cout,
      input  busy, done, result, zero, cout,
             slice_a, slice_b, slice_cin, slice_inv, slice_ctl
   );
endinterface
`default_nettype wire

// File: rtl/serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_seq
// Description : Bit-serial sequencer computing one WIDTH-bit ALU operation
//               through a single external 1-bit ALU slice, LSB first.
//               The slice carry is fed back as the next carry-in; the final
//               result, zero flag and carry are registered at the MSB edge.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - serial_alu_seq_if.slave (issue + slice signals)
// Revision    : 1.0  initial release
// ============================================================================
module serial_alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_alu_seq_if.slave       bus
);

   localparam int            CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
   localparam logic [CW-1:0] c_one  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_ctl;
   logic             r_carry;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_cout;
   logic             r_done;
   logic             r_busy;

   logic             w_inv_in;
   logic             w_inv;
   logic             w_sign;
   logic             w_ovf;
   logic [WIDTH-1:0] w_acc_next;
   logic [WIDTH-1:0] w_final;

   // Subtract and set-less-than both run the slice as a + ~b + 1.
   assign w_inv_in = (bus.ctl == 3'b110) || (bus.ctl == 3'b111);
   assign w_inv    = (r_ctl   == 3'b110) || (r_ctl   == 3'b111);

   // Only meaningful on the MSB cycle: overflow is carry-in xor carry-out
   // of the sign bit, and the signed less-than is sign xor overflow.
   assign w_sign = bus.slice_out;
   assign w_ovf  = r_carry ^ bus.slice_cout;

   // Bits are gathered in r_acc so the visible result only changes once,
   // at the final RUN edge.
   always_comb begin
      w_acc_next        = r_acc;
      w_acc_next[r_cnt] = bus.slice_out;
   end

   always_comb begin
      w_final = w_acc_next;
      if (r_ctl == 3'b111) begin
         w_final    = '0;
         w_final[0] = w_sign ^ w_ovf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_ctl    <= 3'b000;
         r_carry  <= 1'b0;
         r_acc    <= '0;
         r_result <= '0;
         r_zero   <= 1'b0;
         r_cout   <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_ctl   <= bus.ctl;
                  r_carry <= w_inv_in;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_acc   <= w_acc_next;
               r_carry <= bus.slice_cout;
               if (r_cnt == c_last) begin
                  r_cnt    <= '0;
                  r_result <= w_final;
                  r_zero   <= (w_final == '0);
                  r_cout   <= bus.slice_cout;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + c_one;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.result    = r_result;
   assign bus.zero      = r_zero;
   assign bus.cout      = r_cout;
   assign bus.slice_a   = r_a[r_cnt];
   assign bus.slice_b   = r_b[r_cnt];
   assign bus.slice_cin = r_carry;
   assign bus.slice_inv = w_inv;
   assign bus.slice_ctl = r_ctl;

endmodule
`default_nettype wire
